ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the 16-bit pipeline, consuming operands and control straight from the ID/EX register outputs. It performs an unsigned shift-add multiply or a restoring divide, one bit per clock. While an operation is in flight it raises `stall` so upstream stages freeze. It delivers the result with a one-cycle `done` pulse, together with the destination register and write-back flag toward EX/MEM.

---
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv.sv | 153 +++++++++++++++
 tb/tb_ex_muldiv.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for the iterative multiply/divide unit.
// The pipeline side is the master and drives the request, the unit is the slave.
// Clock and reset are plain ports of the unit, not members of this bundle.
interface ex_muldiv_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0]       destIn;
  logic             wbIn;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] resLo;
  logic [WIDTH-1:0] resHi;
  logic [3:0]       outDest;
  logic             outWB;

  modport master (
    output start, op, opA, opB, destIn, wbIn, flush,
    input  busy, stall, done, resLo, resHi, outDest, outWB
  );

  modport slave (
    input  start, op, opA, opB, destIn, wbIn, flush,
    output busy, stall, done, resLo, resHi, outDest, outWB
  );
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage iterative unsigned multiply (shift-add) / restoring divide, one bit per clock.
// Latency: done pulses WIDTH edges after accept; throughput one op per WIDTH+2 cycles.
// Backpressure: stall freezes upstream from accept through the last RUN cycle; divide only with MULDIV_DIV_EN.
module ex_muldiv #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  // Product high half for multiply, remainder for divide. The remainder only
  // needs WIDTH bits between steps because it is always below the divisor;
  // the extra bit exists only in the shifted trial value r_sh.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       dest_q, dest_d;
  logic             wb_q, wb_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       out_dest_q, out_dest_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_lo;

`ifdef MULDIV_DIV_EN
  logic             op_q, op_d;
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
`else
  logic             unused_op;
  assign unused_op = bus.op;
`endif

  // One iteration of the selected algorithm from the current registers.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    step_acc = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    r_sh = {acc_q, lo_q[WIDTH-1]};
    r_ge = (r_sh >= {1'b0, b_q});
    if (op_q) begin
      // A zero divisor always "fits": quotient becomes all ones and the
      // dividend bits simply accumulate into the remainder.
      step_acc = r_ge ? WIDTH'(r_sh - {1'b0, b_q}) : r_sh[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], r_ge};
    end
`endif
  end

  // Next-state and datapath-load decisions for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    b_d        = b_q;
    dest_d     = dest_q;
    wb_d       = wb_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    out_dest_d = out_dest_q;
`ifdef MULDIV_DIV_EN
    op_d       = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          lo_d    = bus.opA;
          b_d     = bus.opB;
          dest_d  = bus.destIn;
          wb_d    = bus.wbIn;
`ifdef MULDIV_DIV_EN
          op_d    = bus.op;
`endif
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d    = DONE;
            res_lo_d   = step_lo;
            res_hi_d   = step_acc;
            out_dest_d = dest_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      wb_q       <= 1'b0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      out_dest_q <= '0;
`ifdef MULDIV_DIV_EN
      op_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      dest_q     <= dest_d;
      wb_q       <= wb_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      out_dest_q <= out_dest_d;
`ifdef MULDIV_DIV_EN
      op_q       <= op_d;
`endif
    end
  end

  // stall is gated by rst so it stays low while reset is held even if start is up.
  assign bus.busy    = (state_q != IDLE);
  assign bus.stall   = rst & ((state_q == RUN) ||
                              ((state_q == IDLE) && bus.start && !bus.flush));
  assign bus.done    = (state_q == DONE) && !bus.flush;
  assign bus.outWB   = bus.done && wb_q;
  assign bus.resLo   = res_lo_q;
  assign bus.resHi   = res_hi_q;
  assign bus.outDest = out_dest_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results, a monitor
// pops and compares on every done pulse; timing/flush/reset checks are inline.
module tb_ex_muldiv;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  dest;
    logic        wb;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  ex_muldiv_if #(.WIDTH(16)) bus ();

  ex_muldiv #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resLo",   bus.resLo,   e.lo);
        check("resHi",   bus.resHi,   e.hi);
        check("outDest", bus.outDest, e.dest);
        check("outWB",   bus.outWB,   e.wb);
      end
    end
  end

  // Drive a request; returns 2 time units after the accepting edge E0.
  task automatic issue_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d, input logic w,
                          input logic [15:0] elo, input logic [15:0] ehi, input bit push);
    exp_t e;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = b;
    bus.destIn = d; bus.wbIn = w;
    if (push) begin
      e.lo = elo; e.hi = ehi; e.dest = d; e.wb = w;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("stall_accept", bus.stall, 1'b1);
    @(posedge clk); #2;
    bus.start = 1'b0; bus.opA = 16'hDEAD; bus.opB = 16'hBEEF;
    bus.destIn = 4'h0; bus.wbIn = 1'b0; bus.op = 1'b0;
  endtask

  // Count negedges until done (bounded) and check the done-cycle handshake.
  task automatic wait_done(input int exp_lat, input logic w);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    check("latency", n, exp_lat);
    check("stall_in_done", bus.stall, 1'b0);
    check("outWB_in_done", bus.outWB, w);
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
    check("outWB_after",    bus.outWB, 1'b0);
    check("busy_after",     bus.busy, 1'b0);
  endtask

  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input logic w,
                        input logic [15:0] elo, input logic [15:0] ehi);
    issue_op(o, a, b, d, w, elo, ehi, 1'b1);
    wait_done(17, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0;
    bus.start = 1'b1; bus.op = 1'b0; bus.opA = 16'h1111; bus.opB = 16'h2222;
    bus.destIn = 4'h7; bus.wbIn = 1'b1; bus.flush = 1'b0;
    #3;
    check("rst_busy",    bus.busy,    1'b0);
    check("rst_stall",   bus.stall,   1'b0);
    check("rst_done",    bus.done,    1'b0);
    check("rst_outWB",   bus.outWB,   1'b0);
    check("rst_resLo",   bus.resLo,   16'h0);
    check("rst_resHi",   bus.resHi,   16'h0);
    check("rst_outDest", bus.outDest, 4'h0);
    bus.start = 1'b0;
    #9 rst = 1'b1;

    run_op(1'b0, 16'h1234, 16'h0056, 4'h3, 1'b0, 16'h1D78, 16'h0006);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 4'h9, 1'b1, 16'h0001, 16'hFFFE);
`ifdef MULDIV_DIV_EN
    run_op(1'b1, 16'd1000, 16'd7, 4'h2, 1'b1, 16'h008E, 16'h0006);
    run_op(1'b1, 16'h1234, 16'h0000, 4'h1, 1'b1, 16'hFFFF, 16'h1234);
`else
    run_op(1'b1, 16'd1000, 16'd7, 4'h2, 1'b1, 16'h1B58, 16'h0000);
    run_op(1'b1, 16'h1234, 16'h0000, 4'h1, 1'b1, 16'h0000, 16'h0000);
`endif

    // Completed multiply, then a flushed one on its 5th RUN cycle.
    run_op(1'b0, 16'h0100, 16'h0100, 4'h4, 1'b1, 16'h0000, 16'h0001);
    issue_op(1'b0, 16'h7777, 16'h3333, 4'h5, 1'b1, 16'h0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #2 bus.flush = 1'b1;
    @(negedge clk);
    check("busy_before_flush", bus.busy, 1'b1);
    @(posedge clk); #2 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",    bus.busy,    1'b0);
    check("flush_stall",   bus.stall,   1'b0);
    check("flush_resLo",   bus.resLo,   16'h0000);
    check("flush_resHi",   bus.resHi,   16'h0001);
    check("flush_outDest", bus.outDest, 4'h4);
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("flush_no_done", n, 0);
    run_op(1'b0, 16'h0003, 16'h0007, 4'hA, 1'b0, 16'h0015, 16'h0000);

    // start pulsed with other operands mid-RUN must be ignored.
    issue_op(1'b0, 16'h00AB, 16'h0010, 4'h6, 1'b1, 16'h0AB0, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.opA = 16'hFFFF; bus.opB = 16'hFFFF; bus.destIn = 4'hF;
    @(negedge clk);
    check("midrun_stall", bus.stall, 1'b1);
    @(posedge clk); #2 bus.start = 1'b0;
    wait_done(13, 1'b1);

    // start together with flush in IDLE is dropped.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.flush = 1'b1; bus.opA = 16'h0002; bus.opB = 16'h0002;
    @(negedge clk);
    check("startflush_stall", bus.stall, 1'b0);
    @(posedge clk); #2;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("startflush_busy", bus.busy, 1'b0);

    // Asynchronous reset on the 8th RUN cycle, between clock edges.
    issue_op(1'b0, 16'h4321, 16'h1111, 4'hC, 1'b1, 16'h0, 16'h0, 1'b0);
    repeat (7) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy",    bus.busy,    1'b0);
    check("arst_stall",   bus.stall,   1'b0);
    check("arst_done",    bus.done,    1'b0);
    check("arst_outWB",   bus.outWB,   1'b0);
    check("arst_resLo",   bus.resLo,   16'h0);
    check("arst_resHi",   bus.resHi,   16'h0);
    check("arst_outDest", bus.outDest, 4'h0);
    @(negedge clk); #2 rst = 1'b1;
    run_op(1'b0, 16'h0003, 16'h0005, 4'h8, 1'b1, 16'h000F, 16'h0000);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
